// File: rtl/sram_ctrl.sv
// sram_ctrl
//   Bridges the MMIO decoder's SRAM request channel to an external 16-bit
//   asynchronous SRAM. Every 32-bit access is split into two halfword
//   accesses, low half first. Each half runs SETUP(1) -> STROBE(WAIT) -> HOLD(1).
//   After both halves, a single DONE cycle pulses ready back to the decoder.
//
// Ports
//   clk, reset        rising-edge clock; asynchronous active-low reset
//   valid / ready     request (held until ready) / one-cycle completion pulse
//   addr, dtw, rw     byte address (bits [1:0] ignored), write data, 1 = write
//   dtr               read data; updated only by reads, held between reads
//   sram_addr         halfword address {addr[AW:2], half}
//   sram_dq_o/_oe/_i  pad write data, pad output enable, pad read data
//   sram_*_n          active-low chip enable, output enable, write enable, byte lanes
module sram_ctrl #(
  parameter int AW   = 18,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid,
  output logic          ready,
  input  logic [31:0]   addr,
  input  logic [31:0]   dtw,
  output logic [31:0]   dtr,
  input  logic          rw,
  output logic [AW-1:0] sram_addr,
  output logic [15:0]   sram_dq_o,
  output logic          sram_dq_oe,
  input  logic [15:0]   sram_dq_i,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic          sram_lb_n,
  output logic          sram_ub_n
);

  localparam logic [3:0] STROBE_LOAD = 4'(WAIT - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic          half;
  logic [3:0]    cnt;
  logic [AW-2:0] word;
  logic [31:0]   wdata;
  logic          wr;
  logic          active;
  logic          strobe;

  // Address bits above the SRAM size and the byte offset are ignored;
  // high bits simply alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:AW+1], addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      half  <= 1'b0;
      cnt   <= 4'd0;
      word  <= '0;
      wdata <= 32'd0;
      wr    <= 1'b0;
      dtr   <= 32'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (valid) begin
            word  <= addr[AW:2];
            wdata <= dtw;
            wr    <= rw;
            half  <= 1'b0;
          end
        end
        SETUP: cnt <= STROBE_LOAD;
        STROBE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!wr) begin
            // Last strobe cycle: the SRAM has had the full strobe width to drive dq.
            if (half) dtr[31:16] <= sram_dq_i;
            else      dtr[15:0]  <= sram_dq_i;
          end
        end
        HOLD: half <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    active     = 1'b0;
    strobe     = 1'b0;
    ready      = 1'b0;
    sram_ce_n  = 1'b1;
    sram_lb_n  = 1'b1;
    sram_ub_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    sram_dq_o  = 16'h0000;
    sram_addr  = {word, half};

    case (state)
      IDLE:    if (valid) state_next = SETUP;
      SETUP:   state_next = STROBE;
      STROBE:  if (cnt == 4'd0) state_next = HOLD;
      HOLD:    state_next = half ? DONE : SETUP;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    active = (state == SETUP) || (state == STROBE) || (state == HOLD);
    strobe = (state == STROBE);
    ready  = (state == DONE);

    if (active) begin
      sram_ce_n = 1'b0;
      sram_lb_n = 1'b0;
      sram_ub_n = 1'b0;
      // Writes drive the pads for the whole half so data is stable around we_n;
      // reads never drive them, so dq_oe and oe_n are never active together.
      if (wr) begin
        sram_dq_oe = 1'b1;
        sram_dq_o  = half ? wdata[31:16] : wdata[15:0];
        sram_we_n  = !strobe;
      end else begin
        sram_oe_n  = !strobe;
      end
    end
  end

endmodule
